// File: rtl/nibble_shift_pkg.sv
// Shared widths, controller states and {SH,L} mode encodings for the nibble shift controller.
package nibble_shift_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   // {SH,L} encodings understood by the downstream shift register
   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_SHIFT = 2'b10;

endpackage

// File: rtl/nibble_shift_ctrl.sv
// Feeds a negedge-sampled 4-bit shift register: accepts a nibble, loads it, then streams it out LSB-first.
// DIN to first BIT_VALID is 2 cycles; BIT_READY low stalls the shift indefinitely.
module nibble_shift_ctrl
   import nibble_shift_pkg::*;
#(
   parameter logic FILL_BIT = 1'b0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NIBBLE_W-1:0] DIN,
   input  logic                DIN_VALID,
   output logic                DIN_READY,
   output logic [NIBBLE_W-1:0] D,
   output logic                L,
   output logic                SH,
   output logic                SI,
   output logic                BIT_VALID,
   input  logic                BIT_READY,
   output logic [1:0]          BIT_IDX,
   output logic                WORD_DONE
);

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [NIBBLE_W-1:0] hold_q, hold_d;
   logic [1:0]          mode;
   logic                ready;
   logic                bit_valid;
   logic                done;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      mode      = MODE_HOLD;
      ready     = 1'b0;
      bit_valid = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (DIN_VALID) begin
               hold_d  = DIN;
               state_d = LOAD;
            end
         end
         LOAD: begin
            mode    = MODE_LOAD;
            cnt_d   = 2'd0;
            state_d = SHIFT;
         end
         SHIFT: begin
            bit_valid = 1'b1;
            if (BIT_READY) begin
               mode  = MODE_SHIFT;
               // wraps to 0 after bit 3, so the counter is clean for the next word
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  done  = 1'b1;
                  ready = 1'b1;
                  if (DIN_VALID) begin
                     hold_d  = DIN;
                     state_d = LOAD;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset parks the FSM in IDLE, which would otherwise advertise ready
   assign DIN_READY = ready & ~RST;
   assign D         = hold_q;
   assign SH        = mode[1];
   assign L         = mode[0];
   assign SI        = FILL_BIT;
   assign BIT_VALID = bit_valid;
   assign BIT_IDX   = cnt_q;
   assign WORD_DONE = done;

endmodule

// File: tb/tb_nibble_shift_ctrl.sv
// Pairs the controller with a negedge shift register model; directed tables, corner sequences and random traffic.
module tb_nibble_shift_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] din, d, q;
   logic       din_valid, din_ready, l, sh, si, bit_valid, bit_ready, word_done;
   logic [1:0] bit_idx;

   logic [3:0] f_din, f_d, f_q;
   logic       f_din_valid, f_din_ready, f_l, f_sh, f_si, f_bit_valid, f_bit_ready, f_word_done;
   logic [1:0] f_bit_idx;

   always #5 clk = ~clk;

   nibble_shift_ctrl u_dut (
      .CLK(clk), .RST(rst), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready),
      .D(d), .L(l), .SH(sh), .SI(si), .BIT_VALID(bit_valid), .BIT_READY(bit_ready),
      .BIT_IDX(bit_idx), .WORD_DONE(word_done)
   );

   nibble_shift_ctrl #(.FILL_BIT(1'b1)) u_fill (
      .CLK(clk), .RST(rst), .DIN(f_din), .DIN_VALID(f_din_valid), .DIN_READY(f_din_ready),
      .D(f_d), .L(f_l), .SH(f_sh), .SI(f_si), .BIT_VALID(f_bit_valid), .BIT_READY(f_bit_ready),
      .BIT_IDX(f_bit_idx), .WORD_DONE(f_word_done)
   );

   // Downstream 4-bit register: shift has priority over load, sampled on the falling edge
   always @(negedge clk or posedge rst) begin
      if (rst) q <= 4'h0;
      else if (sh) q <= {si, q[3:1]};
      else if (l) q <= d;
   end

   always @(negedge clk or posedge rst) begin
      if (rst) f_q <= 4'h0;
      else if (f_sh) f_q <= {f_si, f_q[3:1]};
      else if (f_l) f_q <= f_d;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   int cyc = 0;
   int illegal = 0;
   int l_cnt = 0;
   int bit_q[$], idx_q[$], done_cyc[$], acc_din[$], acc_cyc[$], start_cyc[$];
   logic prev_valid = 1'b0;

   // Observes handshakes a few ns after each rising edge, once inputs have settled
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #3;
         if (!rst) begin
            if (l && sh) illegal++;
            if (l && din_ready) illegal++;
            if (word_done && !(bit_valid && bit_ready && bit_idx == 2'd3)) illegal++;
            if (din_valid && din_ready) begin
               acc_din.push_back(int'(din));
               acc_cyc.push_back(cyc);
            end
            if (bit_valid && bit_ready) begin
               bit_q.push_back(int'(q[0]));
               idx_q.push_back(int'(bit_idx));
            end
            if (word_done) done_cyc.push_back(cyc);
            if (bit_valid && !prev_valid) start_cyc.push_back(cyc);
            if (l) l_cnt++;
         end
         prev_valid = bit_valid;
      end
   end

   task automatic clear_logs();
      bit_q.delete(); idx_q.delete(); done_cyc.delete();
      acc_din.delete(); acc_cyc.delete(); start_cyc.delete();
      l_cnt = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] din;
      int         stall_at;
      int         stall_len;
      logic [3:0] exp_seq;   // delivery order, first bit in [3]
   } vec_t;

   task automatic run_word(input vec_t v, input string tag);
      int stall_left;
      int n;
      bit stalled;
      logic [3:0] q_hold;
      stall_left = v.stall_len;
      n = 0;
      stalled = 0;
      q_hold = 4'h0;
      clear_logs();
      din = v.din;
      din_valid = 1'b1;
      bit_ready = 1'b1;
      while (done_cyc.size() == 0 && n < 40) begin
         tick();
         n++;
         if (stalled) check({tag, "_stall_q"}, int'(q), int'(q_hold));
         stalled = 0;
         if (acc_din.size() > 0) din_valid = 1'b0;
         if (bit_valid && int'(bit_idx) == v.stall_at && stall_left > 0) begin
            bit_ready = 1'b0;
            stall_left--;
            stalled = 1;
            q_hold = q;
            #1;
            check({tag, "_stall_sh"}, int'(sh), 0);
         end else begin
            bit_ready = 1'b1;
         end
      end
      din_valid = 1'b0;
      check({tag, "_timeout"}, int'(n < 40), 1);
      check({tag, "_nbits"}, bit_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < bit_q.size()) begin
            check($sformatf("%s_bit%0d", tag, k), bit_q[k], int'(v.exp_seq[3-k]));
            check($sformatf("%s_idx%0d", tag, k), idx_q[k], k);
         end
      end
      check({tag, "_done_cnt"}, done_cyc.size(), 1);
      if (start_cyc.size() > 0 && acc_cyc.size() > 0)
         check({tag, "_latency"}, start_cyc[0] - acc_cyc[0], 2);
      else
         check({tag, "_latency_seen"}, 0, 1);
   endtask

   vec_t tbl[5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   initial begin
      int n;
      int exp_b2b[8];
      rst = 1'b1;
      din = 4'h0; din_valid = 1'b0; bit_ready = 1'b0;
      f_din = 4'h0; f_din_valid = 1'b0; f_bit_ready = 1'b0;

      tbl[0] = '{din: 4'b1011, stall_at: -1, stall_len: 0, exp_seq: 4'b1101};
      tbl[1] = '{din: 4'h6,    stall_at: 2,  stall_len: 3, exp_seq: 4'b0110};
      tbl[2] = '{din: 4'h9,    stall_at: 0,  stall_len: 2, exp_seq: 4'b1001};
      tbl[3] = '{din: 4'hF,    stall_at: 3,  stall_len: 1, exp_seq: 4'b1111};
      tbl[4] = '{din: 4'hC,    stall_at: 1,  stall_len: 4, exp_seq: 4'b0011};

      // Reset values
      #12;
      check("rst_din_ready", int'(din_ready), 0);
      check("rst_l", int'(l), 0);
      check("rst_sh", int'(sh), 0);
      check("rst_bit_valid", int'(bit_valid), 0);
      check("rst_bit_idx", int'(bit_idx), 0);
      check("rst_word_done", int'(word_done), 0);
      check("rst_d", int'(d), 0);
      check("rst_si", int'(si), 0);
      check("rst_fill_si", int'(f_si), 1);
      tick();
      rst = 1'b0;
      #1;
      check("idle_din_ready", int'(din_ready), 1);

      for (int i = 0; i < 5; i++) run_word(tbl[i], $sformatf("tbl%0d", i));

      // Back-to-back A then 5
      clear_logs();
      din = 4'hA; din_valid = 1'b1; bit_ready = 1'b1;
      n = 0;
      while (done_cyc.size() < 2 && n < 40) begin
         tick();
         n++;
         if (acc_din.size() == 1) din = 4'h5;
         if (acc_din.size() >= 2) din_valid = 1'b0;
      end
      din_valid = 1'b0;
      check("b2b_timeout", int'(n < 40), 1);
      exp_b2b = '{0, 1, 0, 1, 1, 0, 1, 0};
      check("b2b_nbits", bit_q.size(), 8);
      for (int k = 0; k < 8; k++)
         if (k < bit_q.size()) check($sformatf("b2b_bit%0d", k), bit_q[k], exp_b2b[k]);
      check("b2b_done_cnt", done_cyc.size(), 2);
      check("b2b_loads", l_cnt, 2);
      if (done_cyc.size() >= 2 && start_cyc.size() >= 2) begin
         check("b2b_done_gap", done_cyc[1] - done_cyc[0], 5);
         check("b2b_one_load_gap", start_cyc[1] - done_cyc[0], 2);
      end
      tick();

      // Reset mid-word at bit index 1
      clear_logs();
      din = 4'h9; din_valid = 1'b1; bit_ready = 1'b1;
      n = 0;
      while (!(bit_valid && bit_idx == 2'd1) && n < 20) begin
         tick();
         n++;
         if (acc_din.size() > 0) din_valid = 1'b0;
      end
      check("rstmid_reach_idx1", int'(n < 20), 1);
      #1 rst = 1'b1;
      #1;
      check("rstmid_din_ready", int'(din_ready), 0);
      check("rstmid_l", int'(l), 0);
      check("rstmid_sh", int'(sh), 0);
      check("rstmid_bit_valid", int'(bit_valid), 0);
      check("rstmid_bit_idx", int'(bit_idx), 0);
      check("rstmid_word_done", int'(word_done), 0);
      check("rstmid_d", int'(d), 0);
      check("rstmid_si", int'(si), 0);
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rstmid_idle_ready", int'(din_ready), 1);
      tick(); tick();
      check("rstmid_no_done", done_cyc.size(), 0);
      check("rstmid_bits_before", bit_q.size(), 1);
      run_word('{din: 4'h3, stall_at: -1, stall_len: 0, exp_seq: 4'b1100}, "after_rst");

      // FILL_BIT=1 instance shifting a zero nibble
      f_din = 4'h0; f_din_valid = 1'b1; f_bit_ready = 1'b1;
      #1;
      check("fill_ready", int'(f_din_ready), 1);
      tick();
      f_din_valid = 1'b0;
      n = 0;
      while (!f_word_done && n < 20) begin
         tick();
         n++;
      end
      check("fill_done_seen", int'(f_word_done), 1);
      tick();
      check("fill_q", int'(f_q), 15);
      f_bit_ready = 1'b0;

      // Random traffic against the stream model
      clear_logs();
      for (int c = 0; c < 800; c++) begin
         tick();
         din_valid = 1'($urandom_range(0, 1));
         din = 4'($urandom);
         bit_ready = ($urandom_range(0, 9) < 7);
      end
      din_valid = 1'b0;
      bit_ready = 1'b1;
      for (int c = 0; c < 12; c++) tick();
      begin
         int exp_bits[$];
         int exp_idx[$];
         foreach (acc_din[i])
            for (int k = 0; k < 4; k++) begin
               exp_bits.push_back((acc_din[i] >> k) & 1);
               exp_idx.push_back(k);
            end
         check("rand_words_nonzero", int'(acc_din.size() > 10), 1);
         check("rand_nbits", bit_q.size(), exp_bits.size());
         for (int i = 0; i < exp_bits.size() && i < bit_q.size(); i++) begin
            check($sformatf("rand_bit%0d", i), bit_q[i], exp_bits[i]);
            check($sformatf("rand_idx%0d", i), idx_q[i], exp_idx[i]);
         end
         check("rand_done_cnt", done_cyc.size(), acc_din.size());
         check("rand_start_cnt", start_cyc.size(), acc_din.size());
         for (int i = 0; i < acc_cyc.size() && i < start_cyc.size(); i++)
            check($sformatf("rand_latency%0d", i), start_cyc[i] - acc_cyc[i], 2);
      end

      check("protocol_violations", illegal, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nibble_shift_ctrl.md
NIBBLE_SHIFT_CTRL -- requirements
Module: nibble_shift_ctrl

Interface
REQ-001 Parameter: FILL_BIT, default 1'b0, constant value driven on SI during every shift.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  asynchronous, active-high reset.
REQ-004 Port: DIN  input  4  parallel nibble from upstream producer.
REQ-005 Port: DIN_VALID  input  1  DIN holds a valid nibble.
REQ-006 Port: DIN_READY  output  1  controller accepts DIN this cycle.
REQ-007 Port: D  output  4  nibble presented to the 4-bit shift register's parallel inputs; D[0] feeds D0.
REQ-008 Port: L  output  1  load select to the shift register.
REQ-009 Port: SH  output  1  shift select to the shift register.
REQ-010 Port: SI  output  1  serial input to the shift register.
REQ-011 Port: BIT_VALID  output  1  shift register Q0 currently holds a payload bit.
REQ-012 Port: BIT_READY  input  1  downstream consumer takes Q0 this cycle.
REQ-013 Port: BIT_IDX  output  2  index (0..3) of the payload bit now on Q0.
REQ-014 Port: WORD_DONE  output  1  one-cycle pulse on the handshake of bit 3.

Function
REQ-015 Controller is upstream of a negedge-sampled 4-bit register: {SH,L}=00 hold, 01 load D, 1x shift right (SI into Q3, Q0 out); outputs change only after rising edges, so they are stable at the sampling falling edge.
REQ-016 FSM states IDLE, LOAD, SHIFT; 2-bit bit counter CNT; 4-bit holding register HOLD.
REQ-017 IDLE: DIN_READY=1, L=0, SH=0, BIT_VALID=0; on DIN_VALID, HOLD<=DIN, next state LOAD.
REQ-018 LOAD: exactly one cycle; L=1, SH=0, D=HOLD, DIN_READY=0; next state SHIFT, CNT<=0.
REQ-019 SHIFT: BIT_VALID=1, BIT_IDX=CNT, L=0, SH=BIT_READY (combinational), SI=FILL_BIT.
REQ-020 SHIFT with BIT_READY=0: SH=0 (hold), CNT and state unchanged, no bound on stall length.
REQ-021 SHIFT with BIT_READY=1 and CNT<3: CNT<=CNT+1.
REQ-022 SHIFT with BIT_READY=1 and CNT=3: WORD_DONE=1 this cycle; DIN_READY=1 this cycle; if DIN_VALID, HOLD<=DIN and next state LOAD, else IDLE.
REQ-023 DIN_READY=0 in every other SHIFT cycle; DIN is ignored when DIN_READY=0.
REQ-024 Bits leave LSB-first: BIT_IDX k corresponds to HOLD[k] on Q0.
REQ-025 Latency: DIN handshake to first BIT_VALID = 2 cycles; back-to-back words sustain 4 bits per 5 cycles.
REQ-026 D=HOLD in all states; L and SH never both 1.

Reset
REQ-027 RST=1 forces immediately, asynchronously: state IDLE, CNT=0, HOLD=0, D=0, L=0, SH=0, BIT_VALID=0, BIT_IDX=0, WORD_DONE=0, SI=FILL_BIT, DIN_READY=0 while RST is asserted.
REQ-028 Reset mid-word discards the word without a WORD_DONE pulse; the first rising edge after release is in IDLE.

Structure
REQ-029 Shared package nibble_shift_pkg holds NIBBLE_W=4, the state enum (IDLE, LOAD, SHIFT), and the {SH,L} mode encodings HOLD/LOAD/SHIFT.
REQ-030 Single flat module; no sub-module; the shift register is instantiated beside it by the parent.

Verification
REQ-031 Bench pairs the DUT with the shift register; DIN=4'b1011 with DIN_VALID pulse and BIT_READY=1 -> Q0 sequence 1,1,0,1 at BIT_IDX 0..3, WORD_DONE pulse once.
REQ-032 Back-to-back DIN=4'hA then 4'h5 held valid -> bits 0,1,0,1,1,0,1,0, one LOAD cycle between words, two WORD_DONE pulses 5 cycles apart.
REQ-033 DIN=4'h6, BIT_READY low for 3 cycles at BIT_IDX=2 -> SH=0 and Q unchanged during stall; bit 2 (=1) delivered afterwards.
REQ-034 RST asserted mid-SHIFT at BIT_IDX=1 -> outputs take their reset values without a clock edge, no WORD_DONE pulse; the next word 4'h3 is delivered correctly.
REQ-035 FILL_BIT=1, DIN=4'h0 -> after 4 shifts the register holds 4'hF.
REQ-036 Assertion throughout: never L=1 and SH=1 together; DIN_READY=0 in LOAD.
